// File: rtl/connected_run_tracker.sv
// Connected-domain run tracker: classifies 2x3 pixel blocks, follows each run through a
// six-state FSM and emits one registered segment record per qualifying closed run.
module connected_run_tracker #(
    parameter int X_W     = 11,
    parameter int MIN_LEN = 4,
    parameter int MAX_GAP = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_block_valid,
    input  logic [5:0]     i_block,
    input  logic           i_eol,
    input  logic           i_hard_mode,
    output logic           o_seg_valid,
    input  logic           i_seg_ready,
    output logic [X_W-1:0] o_seg_x_start,
    output logic [X_W-1:0] o_seg_x_end,
    output logic [X_W-1:0] o_seg_len,
    output logic           o_seg_hard,
    output logic [2:0]     o_state,
    output logic           o_overflow
);

    localparam int             GAP_W = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
    localparam int             LEN_W = X_W + 1;
    localparam logic [X_W-1:0] X_MAX = '1;

    typedef enum logic [2:0] {
        DETECT        = 3'd0,
        START         = 3'd1,
        CONNECT       = 3'd2,
        PRE_DISC      = 3'd3,
        HARD_CONNECT  = 3'd4,
        HARD_PRE_DISC = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [X_W-1:0]   xs_q, xs_d;
    logic [X_W-1:0]   last_q, last_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             hard_lat_q, hard_lat_d;
    logic             hard_seen_q, hard_seen_d;

    logic             seg_valid_q, seg_valid_d;
    logic [X_W-1:0]   seg_xs_q, seg_xs_d;
    logic [X_W-1:0]   seg_xe_q, seg_xe_d;
    logic [X_W-1:0]   seg_len_q, seg_len_d;
    logic             seg_hard_q, seg_hard_d;
    logic             overflow_q, overflow_d;

    logic             cls_ds, cls_sc, cls_tpd, cls_pds;
    logic             cls_thc, cls_hcpd, cls_hpdc, cls_hpds;
    logic             gap_ok, close_run, keep_run;
    logic [LEN_W-1:0] run_len;

    assign cls_ds   = (i_block == 6'b111100) || (i_block == 6'b111101);
    assign cls_sc   = (i_block == 6'b111000) || (i_block == 6'b111001);
    assign cls_tpd  = ({i_block[5], i_block[4], i_block[2], i_block[1]} == 4'b1101);
    assign cls_pds  = ({i_block[5], i_block[2], i_block[1]} == 3'b111);
    assign cls_thc  = ({i_block[3], i_block[1]} == 2'b00);
    assign cls_hcpd = (i_block[2:1] == 2'b01);
    assign cls_hpdc = (i_block[2:1] == 2'b10);
    assign cls_hpds = (i_block[2:1] == 2'b11);
    assign gap_ok   = (gap_q < GAP_W'(MAX_GAP));

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (i_rst) begin
            state_q     <= DETECT;
            x_q         <= '0;
            xs_q        <= '0;
            last_q      <= '0;
            gap_q       <= '0;
            hard_lat_q  <= 1'b0;
            hard_seen_q <= 1'b0;
            seg_valid_q <= 1'b0;
            seg_xs_q    <= '0;
            seg_xe_q    <= '0;
            seg_len_q   <= '0;
            seg_hard_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            xs_q        <= xs_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            hard_lat_q  <= hard_lat_d;
            hard_seen_q <= hard_seen_d;
            seg_valid_q <= seg_valid_d;
            seg_xs_q    <= seg_xs_d;
            seg_xe_q    <= seg_xe_d;
            seg_len_q   <= seg_len_d;
            seg_hard_q  <= seg_hard_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        x_d         = x_q;
        xs_d        = xs_q;
        last_d      = last_q;
        gap_d       = gap_q;
        hard_lat_d  = hard_lat_q;
        hard_seen_d = hard_seen_q;
        close_run   = 1'b0;

        if (i_block_valid) begin
            unique case (state_q)
                DETECT: begin
                    if (cls_ds) begin
                        state_d     = START;
                        xs_d        = x_q;
                        hard_lat_d  = i_hard_mode;
                        hard_seen_d = 1'b0;
                    end
                end
                START: begin
                    if (cls_sc) begin
                        state_d = CONNECT;
                        last_d  = x_q;
                    end else begin
                        state_d = DETECT;
                    end
                end
                CONNECT: begin
                    if (hard_lat_q && cls_thc) begin
                        state_d     = HARD_CONNECT;
                        hard_seen_d = 1'b1;
                        last_d      = x_q;
                    end else if (cls_tpd) begin
                        state_d = PRE_DISC;
                        gap_d   = GAP_W'(1);
                    end else begin
                        last_d = x_q;
                    end
                end
                PRE_DISC: begin
                    if (cls_ds) begin
                        state_d = CONNECT;
                        last_d  = x_q;
                    end else if (cls_pds && gap_ok) begin
                        gap_d = gap_q + GAP_W'(1);
                    end else begin
                        close_run = 1'b1;
                    end
                end
                HARD_CONNECT: begin
                    if (cls_hcpd) begin
                        state_d = HARD_PRE_DISC;
                        gap_d   = GAP_W'(1);
                    end else begin
                        last_d = x_q;
                    end
                end
                HARD_PRE_DISC: begin
                    if (cls_hpdc) begin
                        state_d = HARD_CONNECT;
                        last_d  = x_q;
                    end else if (cls_hpds && gap_ok) begin
                        gap_d = gap_q + GAP_W'(1);
                    end else begin
                        close_run = 1'b1;
                    end
                end
                default: state_d = DETECT;
            endcase

            if (close_run) begin
                state_d = DETECT;
            end

            // End of line forces any open run closed; a half-started run is simply dropped.
            if (i_eol && (state_d != DETECT)) begin
                close_run = (state_d != START);
                state_d   = DETECT;
            end

            if (i_eol) begin
                x_d = '0;
            end else if (x_q != X_MAX) begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    always_comb begin
        run_len     = {1'b0, last_d} - {1'b0, xs_q} + LEN_W'(1);
        keep_run    = close_run && (run_len >= LEN_W'(MIN_LEN));
        seg_valid_d = seg_valid_q;
        seg_xs_d    = seg_xs_q;
        seg_xe_d    = seg_xe_q;
        seg_len_d   = seg_len_q;
        seg_hard_d  = seg_hard_q;
        overflow_d  = overflow_q;

        // A held record is never overwritten; a record arriving while blocked is lost.
        if (keep_run) begin
            if (!seg_valid_q || i_seg_ready) begin
                seg_valid_d = 1'b1;
                seg_xs_d    = xs_q;
                seg_xe_d    = last_d;
                seg_len_d   = run_len[X_W-1:0];
                seg_hard_d  = hard_seen_d;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (seg_valid_q && i_seg_ready) begin
            seg_valid_d = 1'b0;
        end
    end

    always_comb begin
        o_state       = state_q;
        o_seg_valid   = seg_valid_q;
        o_seg_x_start = seg_xs_q;
        o_seg_x_end   = seg_xe_q;
        o_seg_len     = seg_len_q;
        o_seg_hard    = seg_hard_q;
        o_overflow    = overflow_q;
    end

endmodule

// File: tb/tb_connected_run_tracker.sv
// Bench for connected_run_tracker: table-driven runs, hand-written corner sequences, and a
// random stream checked every cycle against a phase-based behavioural model.
module tb_connected_run_tracker;

    localparam int X_W     = 11;
    localparam int MIN_LEN = 4;
    localparam int MAX_GAP = 2;
    localparam int X_SAT   = (1 << X_W) - 1;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_block_valid;
    logic [5:0]     i_block;
    logic           i_eol;
    logic           i_hard_mode;
    logic           i_seg_ready;
    logic           o_seg_valid;
    logic [X_W-1:0] o_seg_x_start;
    logic [X_W-1:0] o_seg_x_end;
    logic [X_W-1:0] o_seg_len;
    logic           o_seg_hard;
    logic [2:0]     o_state;
    logic           o_overflow;

    always #5 clk = ~clk;

    connected_run_tracker #(
        .X_W(X_W),
        .MIN_LEN(MIN_LEN),
        .MAX_GAP(MAX_GAP)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_block_valid(i_block_valid),
        .i_block(i_block),
        .i_eol(i_eol),
        .i_hard_mode(i_hard_mode),
        .o_seg_valid(o_seg_valid),
        .i_seg_ready(i_seg_ready),
        .o_seg_x_start(o_seg_x_start),
        .o_seg_x_end(o_seg_x_end),
        .o_seg_len(o_seg_len),
        .o_seg_hard(o_seg_hard),
        .o_state(o_state),
        .o_overflow(o_overflow)
    );

    typedef struct {
        int xs;
        int xe;
        int len;
        bit hard;
    } rec_t;

    typedef struct {
        int          n;
        logic [59:0] blk;
        bit          hard;
        int          cnt;
        int          xs;
        int          xe;
        int          len;
        bit          hd;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t got_q[$];

    // Model: a run is idle, armed (start seen) or running; running has a gap flag and a hard flag.
    int   m_x, m_xs, m_last, m_gapn;
    bit   m_armed, m_run, m_gap, m_hard_en, m_hard_now, m_hard_seen;
    bit   m_sv, m_ovf;
    rec_t m_rec;

    logic [5:0] pool [12] = '{6'b111100, 6'b111101, 6'b111000, 6'b111001, 6'b110010, 6'b100110,
                              6'b110100, 6'b000010, 6'b000100, 6'b000110, 6'b111111, 6'b000000};

    always @(negedge clk) begin
        if (!i_rst && o_seg_valid && i_seg_ready)
            got_q.push_back('{int'(o_seg_x_start), int'(o_seg_x_end), int'(o_seg_len), o_seg_hard});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ds(input logic [5:0] b);
        return (b == 6'b111100) || (b == 6'b111101);
    endfunction

    function automatic bit is_sc(input logic [5:0] b);
        return (b == 6'b111000) || (b == 6'b111001);
    endfunction

    function automatic logic [31:0] exp_state();
        if (m_run) return 2 + (m_hard_now ? 2 : 0) + (m_gap ? 1 : 0);
        return m_armed ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_x = 0; m_xs = 0; m_last = 0; m_gapn = 0;
        m_armed = 0; m_run = 0; m_gap = 0; m_hard_en = 0; m_hard_now = 0; m_hard_seen = 0;
        m_sv = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input logic [5:0] b, input bit e, input bit h, input bit r);
        bit   have_new = 0;
        bit   closed   = 0;
        rec_t nr;
        if (v) begin
            if (m_run && !m_gap) begin
                if (!m_hard_now && m_hard_en && b[3] == 0 && b[1] == 0) begin
                    m_hard_now = 1; m_hard_seen = 1; m_last = m_x;
                end else if (!m_hard_now && {b[5], b[4], b[2], b[1]} == 4'b1101) begin
                    m_gap = 1; m_gapn = 1;
                end else if (m_hard_now && b[2:1] == 2'b01) begin
                    m_gap = 1; m_gapn = 1;
                end else begin
                    m_last = m_x;
                end
            end else if (m_run) begin
                bit rejoin = m_hard_now ? (b[2:1] == 2'b10) : is_ds(b);
                bit hold   = m_hard_now ? (b[2:1] == 2'b11) : ({b[5], b[2], b[1]} == 3'b111);
                if (rejoin) begin
                    m_gap = 0; m_last = m_x;
                end else if (hold && m_gapn < MAX_GAP) begin
                    m_gapn++;
                end else begin
                    closed = 1;
                end
            end else if (m_armed) begin
                m_armed = 0;
                if (is_sc(b)) begin
                    m_run = 1; m_gap = 0; m_hard_now = 0; m_last = m_x;
                end
            end else if (is_ds(b)) begin
                m_armed = 1; m_xs = m_x; m_hard_en = h; m_hard_seen = 0;
            end
            if (e) begin
                if (m_armed) m_armed = 0;
                else if (m_run && !closed) closed = 1;
            end
            if (closed) begin
                int len = m_last - m_xs + 1;
                m_run = 0; m_gap = 0; m_hard_now = 0;
                if (len >= MIN_LEN) begin
                    have_new = 1;
                    nr = '{m_xs, m_last, len, m_hard_seen};
                end
            end
            m_x = e ? 0 : ((m_x < X_SAT) ? m_x + 1 : X_SAT);
        end
        if (have_new) begin
            if (!m_sv || r) begin
                m_sv = 1; m_rec = nr;
            end else begin
                m_ovf = 1;
            end
        end else if (m_sv && r) begin
            m_sv = 0;
        end
    endtask

    task automatic compare_model();
        check("state", o_state, exp_state());
        check("seg_valid", o_seg_valid, m_sv);
        check("overflow", o_overflow, m_ovf);
        if (m_sv) begin
            check("seg_x_start", o_seg_x_start, m_rec.xs);
            check("seg_x_end", o_seg_x_end, m_rec.xe);
            check("seg_len", o_seg_len, m_rec.len & X_SAT);
            check("seg_hard", o_seg_hard, m_rec.hard);
        end
    endtask

    task automatic cycle(input bit v, input logic [5:0] b, input bit e, input bit h, input bit r);
        i_block_valid = v; i_block = b; i_eol = e; i_hard_mode = h; i_seg_ready = r;
        @(posedge clk);
        model_step(v, b, e, h, r);
        #1;
        compare_model();
    endtask

    task automatic idle(input bit r);
        cycle(0, 6'b000000, 0, 0, r);
    endtask

    task automatic do_reset();
        i_rst = 1; i_block_valid = 0; i_block = '0; i_eol = 0; i_hard_mode = 0; i_seg_ready = 0;
        @(posedge clk);
        model_reset();
        #1;
        i_rst = 0;
        check("reset state", o_state, 0);
        check("reset seg_valid", o_seg_valid, 0);
        check("reset overflow", o_overflow, 0);
        check("reset fields", {o_seg_x_start, o_seg_x_end, o_seg_len, o_seg_hard}, 0);
    endtask

    // Four-long soft run from the current column: start, three connects, pre-disc, close.
    task automatic std_run(input bit r);
        cycle(1, 6'b111100, 0, 0, r);
        for (int k = 0; k < 3; k++) cycle(1, 6'b111000, 0, 0, r);
        cycle(1, 6'b110010, 0, 0, r);
        cycle(1, 6'b000000, 0, 0, r);
    endtask

    initial begin
        vec_t vec [9];
        vec[0] = '{9, {6'b000000, 6'b111100, 6'b111000, 6'b111000, 6'b111000, 6'b111000, 6'b111000,
                       6'b110010, 6'b000000, 6'b000000}, 1'b0, 1, 1, 6, 6, 1'b0};
        vec[1] = '{5, {6'b000000, 6'b111100, 6'b111000, 6'b110010, 6'b000000, 6'b000000, 6'b000000,
                       6'b000000, 6'b000000, 6'b000000}, 1'b0, 0, 0, 0, 0, 1'b0};
        vec[2] = '{8, {6'b000000, 6'b111100, 6'b111000, 6'b110100, 6'b000010, 6'b000100, 6'b000010,
                       6'b000000, 6'b000000, 6'b000000}, 1'b1, 1, 1, 5, 5, 1'b1};
        vec[3] = '{10, {6'b000000, 6'b111100, 6'b111000, 6'b110100, 6'b000010, 6'b000100, 6'b000010,
                        6'b000000, 6'b110010, 6'b000000}, 1'b0, 1, 1, 7, 7, 1'b0};
        vec[4] = '{9, {6'b111100, 6'b111000, 6'b111000, 6'b110010, 6'b100110, 6'b111100, 6'b110010,
                       6'b100110, 6'b100110, 6'b000000}, 1'b0, 1, 0, 5, 6, 1'b0};
        vec[5] = '{6, {6'b111100, 6'b111000, 6'b111000, 6'b111000, 6'b110010, 6'b000000, 6'b000000,
                       6'b000000, 6'b000000, 6'b000000}, 1'b0, 1, 0, 3, 4, 1'b0};
        vec[6] = '{5, {6'b111100, 6'b111000, 6'b111000, 6'b110010, 6'b000000, 6'b000000, 6'b000000,
                       6'b000000, 6'b000000, 6'b000000}, 1'b0, 0, 0, 0, 0, 1'b0};
        vec[7] = '{9, {6'b111100, 6'b000000, 6'b111100, 6'b111000, 6'b111000, 6'b111000, 6'b111000,
                       6'b110010, 6'b000000, 6'b000000}, 1'b0, 1, 2, 6, 5, 1'b0};
        vec[8] = '{8, {6'b111100, 6'b111000, 6'b111000, 6'b110100, 6'b000100, 6'b000010, 6'b000110,
                       6'b000110, 6'b000000, 6'b000000}, 1'b1, 1, 0, 4, 5, 1'b1};

        i_rst = 1; i_block_valid = 0; i_block = '0; i_eol = 0; i_hard_mode = 0; i_seg_ready = 0;
        do_reset();

        for (int t = 0; t < 9; t++) begin
            do_reset();
            got_q.delete();
            for (int k = 0; k < vec[t].n; k++) cycle(1, vec[t].blk[59 - 6 * k -: 6], 0, vec[t].hard, 1);
            idle(1);
            idle(1);
            check($sformatf("vec%0d count", t), got_q.size(), vec[t].cnt);
            if (vec[t].cnt > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d xs", t), got_q[0].xs, vec[t].xs);
                check($sformatf("vec%0d xe", t), got_q[0].xe, vec[t].xe);
                check($sformatf("vec%0d len", t), got_q[0].len, vec[t].len);
                check($sformatf("vec%0d hard", t), got_q[0].hard, vec[t].hd);
            end
        end

        // Backpressure: first record held, second dropped, overflow sticks.
        do_reset();
        got_q.delete();
        std_run(0);
        cycle(1, 6'b111100, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 6'b111000, 0, 0, 0);
        cycle(1, 6'b110010, 0, 0, 0);
        cycle(1, 6'b000000, 0, 0, 0);
        check("held valid", o_seg_valid, 1);
        check("held xs", o_seg_x_start, 0);
        check("held xe", o_seg_x_end, 3);
        check("held len", o_seg_len, 4);
        check("overflow set", o_overflow, 1);
        idle(1);
        check("drained valid", o_seg_valid, 0);
        check("overflow sticky", o_overflow, 1);
        check("accepted count", got_q.size(), 1);

        // Reset in the middle of a run clears everything and restarts the column count.
        cycle(1, 6'b111100, 0, 0, 1);
        cycle(1, 6'b111000, 0, 0, 1);
        cycle(1, 6'b111000, 0, 0, 1);
        check("pre-reset state", o_state, 2);
        do_reset();
        got_q.delete();
        std_run(1);
        idle(1);
        check("post-reset count", got_q.size(), 1);
        if (got_q.size() > 0) check("post-reset xs", got_q[0].xs, 0);

        // End of line closes the run at the EOL column and restarts x at 0.
        do_reset();
        got_q.delete();
        cycle(1, 6'b111100, 0, 0, 1);
        for (int k = 1; k < 10; k++) cycle(1, 6'b111000, (k == 9), 0, 1);
        std_run(1);
        cycle(1, 6'b111100, 1, 0, 1);
        check("eol start abort state", o_state, 0);
        idle(1);
        idle(1);
        check("eol count", got_q.size(), 2);
        if (got_q.size() > 1) begin
            check("eol xs", got_q[0].xs, 0);
            check("eol xe", got_q[0].xe, 9);
            check("eol len", got_q[0].len, 10);
            check("after eol xs", got_q[1].xs, 0);
            check("after eol xe", got_q[1].xe, 3);
        end

        // Random stream against the model, then a long line that saturates the column counter.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] b;
            b = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 11)] : 6'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 8, b, $urandom_range(0, 29) == 0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            end
        end
        for (int i = 0; i < 2200; i++) begin
            logic [5:0] b;
            b = pool[$urandom_range(0, 11)];
            cycle(1, b, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 6; i++) cycle(1, pool[$urandom_range(0, 11)], (i == 5), 0, 1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
